// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// The stall codes are the contract with the if_id, id_ex, ex_mem and mem_wb pipeline registers.
package pipe_hazard_ctrl_pkg;

    localparam int STALL_WIDTH     = 2;
    localparam int REG_ADDR_WIDTH  = 5;
    localparam int FLUSH_CNT_WIDTH = 3;   // holds up to FLUSH_CYCLES = 7
    localparam int WAIT_CNT_WIDTH  = 16;  // holds up to MEM_TIMEOUT = 65535

    typedef logic [STALL_WIDTH:0]      stall_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    localparam stall_t STALL_NONE   = 3'd0;
    localparam stall_t STALL_LOAD   = 3'd1;
    localparam stall_t STALL_BRANCH = 3'd2;
    localparam stall_t STALL_MEM    = 3'd3;
    localparam stall_t STALL_FETCH  = 3'd4;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        BR_FLUSH
    } hz_state_t;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic      mem_read_ex,
        input reg_addr_t rd_addr_ex,
        input logic      rs1_rd_en_id,
        input reg_addr_t rs1_addr_id,
        input logic      rs2_rd_en_id,
        input reg_addr_t rs2_addr_id
    );
        return mem_read_ex && (rd_addr_ex != '0) &&
               ((rs1_rd_en_id && (rs1_addr_id == rd_addr_ex)) ||
                (rs2_rd_en_id && (rs2_addr_id == rd_addr_ex)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-detection inputs gathered from ID/EX/MEM and the memories, plus the stall code back.
// master: pipeline side driving hazard information; slave: the stall sequencer.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    reg_addr_t rs1_addr_id;
    reg_addr_t rs2_addr_id;
    logic      rs1_rd_en_id;
    logic      rs2_rd_en_id;
    reg_addr_t rd_addr_ex;
    logic      mem_read_ex;
    logic      branch_taken_ex;
    logic      dmem_req_mem;
    logic      dmem_ready;
    logic      imem_ready;
    stall_t    stall;
    logic      busy;

    modport master (
        output rs1_addr_id, rs2_addr_id, rs1_rd_en_id, rs2_rd_en_id,
        output rd_addr_ex, mem_read_ex, branch_taken_ex,
        output dmem_req_mem, dmem_ready, imem_ready,
        input  stall, busy
    );

    modport slave (
        input  rs1_addr_id, rs2_addr_id, rs1_rd_en_id, rs2_rd_en_id,
        input  rd_addr_ex, mem_read_ex, branch_taken_ex,
        input  dmem_req_mem, dmem_ready, imem_ready,
        output stall, busy
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritised stall code,
// pending-branch tracking across memory waits, sticky timeout flag and perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    hz,
    output logic                 mem_timeout_err,
    output logic [CNT_WIDTH-1:0] cnt_load_stall,
    output logic [CNT_WIDTH-1:0] cnt_branch_flush,
    output logic [CNT_WIDTH-1:0] cnt_mem_wait
);

    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LOAD  = FLUSH_CNT_WIDTH'(FLUSH_CYCLES);
    localparam logic [WAIT_CNT_WIDTH-1:0]  TIMEOUT_VAL = WAIT_CNT_WIDTH'(MEM_TIMEOUT);

    hz_state_t                  state, state_nxt;
    logic [FLUSH_CNT_WIDTH-1:0] flush_cnt, flush_nxt;
    logic [WAIT_CNT_WIDTH-1:0]  wait_cnt, wait_nxt;
    logic                       pend_br, pend_nxt;
    logic                       err_nxt;
    logic                       load_use;
    logic                       mem_block;
    stall_t                     stall_c;

    assign load_use = load_use_hazard(hz.mem_read_ex, hz.rd_addr_ex,
                                      hz.rs1_rd_en_id, hz.rs1_addr_id,
                                      hz.rs2_rd_en_id, hz.rs2_addr_id);

    // Once waiting, only dmem_ready releases the stall; elsewhere a new request must be outstanding.
    assign mem_block = (state == MEM_WAIT) ? !hz.dmem_ready
                                           : (hz.dmem_req_mem && !hz.dmem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            flush_cnt       <= '0;
            wait_cnt        <= '0;
            pend_br         <= 1'b0;
            mem_timeout_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            flush_cnt       <= flush_nxt;
            wait_cnt        <= wait_nxt;
            pend_br         <= pend_nxt;
            mem_timeout_err <= err_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        flush_nxt = flush_cnt;
        wait_nxt  = wait_cnt;
        pend_nxt  = pend_br;
        err_nxt   = mem_timeout_err;
        stall_c   = STALL_NONE;

        if (mem_block) begin
            stall_c   = STALL_MEM;
            state_nxt = MEM_WAIT;
            wait_nxt  = (wait_cnt >= TIMEOUT_VAL) ? wait_cnt : wait_cnt + 1'b1;
            if (wait_nxt == TIMEOUT_VAL) begin
                err_nxt = 1'b1;
            end
            // flush_cnt holds the flush cycles still owed once the wait ends.
            unique case (state)
                RUN: begin
                    if (hz.branch_taken_ex) begin
                        pend_nxt  = 1'b1;
                        flush_nxt = FLUSH_LOAD;
                    end
                end
                MEM_WAIT: begin
                    if (hz.branch_taken_ex && !pend_br) begin
                        pend_nxt  = 1'b1;
                        flush_nxt = FLUSH_LOAD;
                    end
                end
                BR_FLUSH: pend_nxt = 1'b1;
                default:  state_nxt = RUN;
            endcase
        end else begin
            wait_nxt = '0;
            if ((state == BR_FLUSH) || pend_br) begin
                // Flushing masks load-use and fetch waits.
                stall_c   = STALL_BRANCH;
                pend_nxt  = 1'b0;
                flush_nxt = flush_cnt - 1'b1;
                state_nxt = (flush_cnt == 1) ? RUN : BR_FLUSH;
            end else if (hz.branch_taken_ex) begin
                stall_c   = STALL_BRANCH;
                flush_nxt = FLUSH_LOAD - 1'b1;
                state_nxt = (FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
            end else begin
                state_nxt = RUN;
                if (load_use) begin
                    stall_c = STALL_LOAD;
                end else if (!hz.imem_ready) begin
                    stall_c = STALL_FETCH;
                end
            end
        end
    end

    assign hz.stall = stall_c;
    assign hz.busy  = (state != RUN);

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_load (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_c == STALL_LOAD),
        .count (cnt_load_stall)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_branch (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_c == STALL_BRANCH),
        .count (cnt_branch_flush)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_mem (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_c == STALL_MEM),
        .count (cnt_mem_wait)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall and flush sequencer for the 5-stage pipeline. It produces the single `stall` code consumed by the if_id, id_ex, ex_mem and mem_wb pipeline registers. Stall sources, in priority order: data-memory wait, taken branch, load-use hazard, instruction-fetch wait. It also keeps saturating performance counters and a sticky memory-timeout error flag.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles STALL_BRANCH is held after a taken branch (range 1..7).
- MEM_TIMEOUT, 255, number of MEM_WAIT cycles after which mem_timeout_err sets (range 1..65535).
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rs1_addr_id  in  REG_ADDR_WIDTH  rs1 address of the instruction in ID
- rs2_addr_id  in  REG_ADDR_WIDTH  rs2 address of the instruction in ID
- rs1_rd_en_id  in  1  ID instruction reads rs1
- rs2_rd_en_id  in  1  ID instruction reads rs2
- rd_addr_ex  in  REG_ADDR_WIDTH  destination register of the instruction in EX
- mem_read_ex  in  1  EX instruction is a load
- branch_taken_ex  in  1  EX resolved a taken branch or jump (1-cycle pulse)
- dmem_req_mem  in  1  MEM stage has an active load or store
- dmem_ready  in  1  data memory completes the request this cycle
- imem_ready  in  1  instruction memory has valid data this cycle
- stall  out  STALL_WIDTH+1  stall code to all pipeline registers
- busy  out  1  FSM not in RUN
- mem_timeout_err  out  1  sticky error flag
- cnt_load_stall  out  CNT_WIDTH  count of load-use bubbles
- cnt_branch_flush  out  CNT_WIDTH  count of branch flush cycles
- cnt_mem_wait  out  CNT_WIDTH  count of data-memory wait cycles

Behaviour:
- Clock and reset: clk, rst (synchronous, active-high). All state updates on posedge clk.
- `stall` is combinational from FSM state plus current inputs, with no added latency. Everything else is registered.
- Reset values: state=RUN, flush counter=0, wait counter=0, mem_timeout_err=0, all cnt_*=0. With no hazard inputs active after reset, stall=STALL_NONE and busy=0.
- Load-use hazard (load_use):
  - Condition: mem_read_ex && rd_addr_ex!=0 && ((rs1_rd_en_id && rs1_addr_id==rd_addr_ex) || (rs2_rd_en_id && rs2_addr_id==rd_addr_ex)).
  - Action: 1-cycle STALL_LOAD, no state change. The bubble clears mem_read_ex, so no repeat.
- FSM states:
  - RUN:
    - dmem_req_mem && !dmem_ready: stall=STALL_MEM, go to MEM_WAIT.
    - Else branch_taken_ex: stall=STALL_BRANCH, flush counter=FLUSH_CYCLES-1. Go to BR_FLUSH if FLUSH_CYCLES>1, else stay in RUN.
    - Else load_use: stall=STALL_LOAD.
    - Else !imem_ready: stall=STALL_FETCH.
    - Else stall=STALL_NONE.
  - MEM_WAIT:
    - Every cycle: stall=STALL_MEM, wait counter increments.
    - On dmem_ready: clear the wait counter. Return to RUN, or to BR_FLUSH if a branch was latched during the wait.
    - When the wait counter reaches MEM_TIMEOUT: set mem_timeout_err and keep waiting. The flag clears only on rst.
  - BR_FLUSH:
    - stall=STALL_BRANCH; decrement the flush counter, go to RUN when it reaches 0.
    - A new dmem_req_mem && !dmem_ready takes priority: go to MEM_WAIT, keeping the remaining flush count.
    - Load-use and fetch wait are masked while flushing.
- branch_taken_ex during MEM_WAIT is latched in a pending bit, so it is not lost. A second branch while one is pending is impossible, because EX is frozen during the wait.
- busy = (state != RUN).
- Counters:
  - Increment by 1 in each cycle that stall equals the matching code.
  - Saturate at all-ones, never wrap.
  - STALL_FETCH is not counted.
- rst mid-operation: synchronous reset overrides everything in the same edge, from any state, including a pending branch.

Decomposition:
- Shared `defines.sv` additions:
  - STALL_WIDTH=2.
  - Codes: STALL_NONE=3'd0, STALL_LOAD=3'd1, STALL_BRANCH=3'd2, STALL_MEM=3'd3, STALL_FETCH=3'd4.
  - REG_ADDR_WIDTH=5.
  - State enum hz_state_t {RUN, MEM_WAIT, BR_FLUSH}.
- Sub-module sat_counter (CNT_WIDTH, inc, rst), instantiated three times.

Test Plan:
- load_use rs1: mem_read_ex=1, rd_addr_ex=5, rs1_addr_id=5, rs1_rd_en_id=1 -> stall=1 for exactly 1 cycle, cnt_load_stall=1.
- load_use to x0: rd_addr_ex=0, rs1_addr_id=0, rs1_rd_en_id=1 -> stall=0.
- Taken branch, FLUSH_CYCLES=2: branch_taken_ex pulse -> stall=2 for 2 cycles, busy=1 on cycle 2 only, cnt_branch_flush=2.
- Memory wait: dmem_req_mem=1, dmem_ready low 4 cycles -> stall=3 for 4 cycles, back to RUN on the ready cycle, cnt_mem_wait=4.
- Priority and pending branch: dmem wait with branch_taken_ex pulse in cycle 1 -> STALL_MEM until ready, then STALL_BRANCH for 2 cycles. Load_use asserted simultaneously is ignored throughout.
- Timeout and reset: MEM_TIMEOUT=8 with dmem_ready held low 10 cycles -> mem_timeout_err=1 from the 8th wait cycle. Then rst=1 for 1 cycle -> state RUN, err=0, counters=0, stall=0.
